scv_timing_gen: RTL

SCV_TIMING_GEN -- requirements
Module: scv_timing_gen

---
 rtl/scv_pkg.sv | 20 ++
 rtl/scv_interval_timer.sv | 54 +++++
 rtl/scv_timing_gen.sv | 109 ++++++++++
 3 files changed

// File: rtl/scv_pkg.sv
// Shared definitions for the SCV timing generator: CPU phase encoding and
// NTSC vertical-blank interval lengths in CLK cycles.
package scv_pkg;

  typedef enum logic [1:0] {
    P0 = 2'd0,
    P1 = 2'd1,
    P2 = 2'd2,
    P3 = 2'd3
  } phase_e;

  localparam int unsigned VBL_LEN1_NTSC = 12464;
  localparam int unsigned VBL_LEN0_NTSC = 120872;

  // Strobe vector bit order: [0] CP1 rise, [1] CP1 fall, [2] CP2 rise, [3] CP2 fall.
  function automatic logic [3:0] phase_strobe(input phase_e p);
    return 4'b0001 << p;
  endfunction

endpackage

// File: rtl/scv_interval_timer.sv
// Two-level interval timer: level low for len0 cycles, high for len1 cycles.
// Lengths are captured when an interval begins; a zero length counts as one.
module scv_interval_timer #(
  parameter int VW = 20
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          ce_i,
  input  logic [VW-1:0] len0_i,
  input  logic [VW-1:0] len1_i,
  output logic          lvl_o,
  output logic          rise_o
);

  logic [VW-1:0] cnt_q, cnt_d;
  logic          lvl_q, lvl_d;
  logic          rise_q, rise_d;

  function automatic logic [VW-1:0] clamp_len(input logic [VW-1:0] len);
    return (len == '0) ? VW'(1) : len;
  endfunction

  always_comb begin
    cnt_d  = cnt_q;
    lvl_d  = lvl_q;
    rise_d = 1'b0;
    if (ce_i) begin
      // cnt_q holds cycles left in the current interval, including this one
      if (cnt_q <= VW'(1)) begin
        lvl_d  = ~lvl_q;
        rise_d = ~lvl_q;
        cnt_d  = clamp_len(lvl_q ? len0_i : len1_i);
      end else begin
        cnt_d = cnt_q - VW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q  <= clamp_len(len0_i);
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      lvl_q  <= lvl_d;
      rise_q <= rise_d;
    end
  end

  assign lvl_o  = lvl_q;
  assign rise_o = rise_q;

endmodule

// File: rtl/scv_timing_gen.sv
// SCV CPU phase sequencer (CP1/CP2 strobes and levels) plus vertical-blank timer.
// Frame counter is built only when SCV_TIMING_FRAME_CNT_EN is defined.
module scv_timing_gen
  import scv_pkg::*;
#(
  parameter int CKDIV = 1,
  parameter int VW    = 20
) (
  input  logic          CLK,
  input  logic          RESETB,
  input  logic          CE,
  input  logic          STALL,
  input  logic [VW-1:0] VBL_LEN0,
  input  logic [VW-1:0] VBL_LEN1,
  output logic          CP1_POSEDGE,
  output logic          CP1_NEGEDGE,
  output logic          CP2_POSEDGE,
  output logic          CP2_NEGEDGE,
  output logic          CP1,
  output logic          CP2,
  output logic          VBL,
  output logic          VBL_START,
  output logic [15:0]   FRAME_CNT
);

  localparam int DW = (CKDIV > 1) ? $clog2(CKDIV) : 1;

  phase_e        phase_q, phase_d;
  logic [DW-1:0] div_q, div_d;
  logic [3:0]    strb_q, strb_d;
  logic          cp1_q, cp1_d;
  logic          cp2_q, cp2_d;
  logic          run;

  assign run = CE & ~STALL;

  always_comb begin
    phase_d = phase_q;
    div_d   = div_q;
    strb_d  = 4'b0000;
    // Levels follow the strobes one cycle late, so a fall strobe cycle is still high.
    cp1_d   = strb_q[0] ? 1'b1 : (strb_q[1] ? 1'b0 : cp1_q);
    cp2_d   = strb_q[2] ? 1'b1 : (strb_q[3] ? 1'b0 : cp2_q);
    if (run) begin
      if (div_q == '0) begin
        strb_d = phase_strobe(phase_q);
      end
      if (div_q == DW'(CKDIV - 1)) begin
        div_d   = '0;
        phase_d = phase_e'(phase_q + 2'd1);
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETB) begin
      phase_q <= P0;
      div_q   <= '0;
      strb_q  <= 4'b0000;
      cp1_q   <= 1'b0;
      cp2_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      div_q   <= div_d;
      strb_q  <= strb_d;
      cp1_q   <= cp1_d;
      cp2_q   <= cp2_d;
    end
  end

  assign CP1_POSEDGE = strb_q[0];
  assign CP1_NEGEDGE = strb_q[1];
  assign CP2_POSEDGE = strb_q[2];
  assign CP2_NEGEDGE = strb_q[3];
  assign CP1         = cp1_q;
  assign CP2         = cp2_q;

  scv_interval_timer #(
    .VW(VW)
  ) u_vbl_timer (
    .clk_i  (CLK),
    .rst_n_i(RESETB),
    .ce_i   (CE),
    .len0_i (VBL_LEN0),
    .len1_i (VBL_LEN1),
    .lvl_o  (VBL),
    .rise_o (VBL_START)
  );

`ifdef SCV_TIMING_FRAME_CNT_EN
  logic [15:0] frame_q;

  // Counts on the registered start pulse, so the count lags VBL_START by a cycle.
  always_ff @(posedge CLK) begin
    if (!RESETB) begin
      frame_q <= 16'd0;
    end else if (VBL_START) begin
      frame_q <= frame_q + 16'd1;
    end
  end

  assign FRAME_CNT = frame_q;
`else
  assign FRAME_CNT = 16'd0;
`endif

endmodule
